mdu_div: RTL and testbench

- Iterative RV32M divide/remainder unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file operands (rs1 value, rs2 value) and the destination register index.
- Produces a 32-bit result plus a write-back strobe toward the register file write port.
- Stalls the pipeline through busy while a multi-cycle divide is in flight.

---
 rtl/mdu_div.sv | 176 +++++++++++++++++
 tb/tb_mdu_div.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div.sv
// mdu_div: iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division on operand magnitudes produces one quotient bit per
// cycle. Signs are applied in a single fix-up cycle at the end, and the
// result is registered for write-back.

module mdu_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            write_reg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Iteration and datapath registers
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  divisor;
    logic             is_rem;
    logic             neg_quo;
    logic             neg_rem;
    logic [4:0]       rd_latch;

    // Decode of the launch request and its operands
    logic            accept;
    logic            op_signed;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    // One restoring step, done XLEN+1 bits wide so the compare sees the bit shifted out
    logic            last_iter;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;

    // Sign-corrected values selected in FIX
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign accept    = (state == IDLE) && start && funct3[2] && !flush;
    assign op_signed = !funct3[0];
    assign div_zero  = (rs2_data == '0);
    assign overflow  = op_signed
                       && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (rs2_data == {XLEN{1'b1}});
    assign special   = div_zero || overflow;
    assign abs_a     = (op_signed && rs1_data[XLEN-1]) ? (~rs1_data + 1'b1) : rs1_data;
    assign abs_b     = (op_signed && rs2_data[XLEN-1]) ? (~rs2_data + 1'b1) : rs2_data;

    assign last_iter = (count == CNT_W'(XLEN-1));
    assign shifted   = {rem, quo[XLEN-1]};
    assign fits      = (shifted >= {1'b0, divisor});
    assign diff      = shifted[XLEN-1:0] - divisor;

    assign quo_fixed = neg_quo ? (~quo + 1'b1) : quo;
    assign rem_fixed = neg_rem ? (~rem + 1'b1) : rem;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign write_reg = done && (rd_out != 5'd0);

    // State register: synchronous active-low reset returns the unit to IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Special cases skip CALC but still pass through FIX,
    // so the result register is written in one place only.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? FIX : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = flush ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch on accept, then one restoring step per CALC cycle.
    // Special cases preload the final quotient/remainder with no sign fix-up.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            is_rem   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            rd_latch <= 5'd0;
        end else if (accept) begin
            count    <= '0;
            divisor  <= abs_b;
            is_rem   <= funct3[1];
            rd_latch <= rd_in;
            if (div_zero) begin
                quo     <= {XLEN{1'b1}};
                rem     <= rs1_data;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end else if (overflow) begin
                quo     <= {1'b1, {(XLEN-1){1'b0}}};
                rem     <= '0;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end else begin
                quo     <= abs_a;
                rem     <= '0;
                neg_quo <= op_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                neg_rem <= op_signed && rs1_data[XLEN-1];
            end
        end else if (state == CALC) begin
            count <= count + 1'b1;
            rem   <= fits ? diff : shifted[XLEN-1:0];
            quo   <= {quo[XLEN-2:0], fits};
        end
    end

    // Result and destination index update only on a completed FIX.
    // Flushes leave the previous values in place.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= '0;
            rd_out <= 5'd0;
        end else if ((state == FIX) && !flush) begin
            result <= is_rem ? rem_fixed : quo_fixed;
            rd_out <= rd_latch;
        end
    end

endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: self-checking bench for mdu_div. It compares against an
// arithmetic reference model of the RV32M divide rules.

module tb_mdu_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        write_reg;

    int          checks;
    int          passes;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    mdu_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .write_reg (write_reg)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: RV32M divide semantics written with plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic is_signed;
        logic is_rem;
        is_signed = !f3[0];
        is_rem    = f3[1];
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed)
            return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return is_rem ? (a % b) : (a / b);
    endfunction

    // Expected cycles from the accepting edge to the done sample
    function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one operation and wait (bounded) for done; reports what was seen
    task automatic issue_and_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                                  output logic wr, output int lat, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; busy_ok = 1'b1; res = '0; rdo = '0; wr = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k; res = result; rdo = rd_out; wr = write_reg;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b100;
        rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, write_reg, result, rd_out} !== 40'd0)
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b wr=%b result=%h rd=%0d, expected all zero",
                     busy, done, write_reg, result, rd_out);
        else passes++;
        reset = 1'b1;
        last_result = '0; last_rd = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [8] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                 32'd1234, 32'd1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF,
                                 32'hFFFF_FFFF, 32'd1234, 32'h8000_0000, 32'h0};
        int          elat[8] = '{33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        wr;
        int          lat;
        logic        bok;
        for (int i = 0; i < 8; i++) begin
            issue_and_wait(f3s[i], as[i], bs[i], 5'd5, res, rdo, wr, lat, bok);
            checks++;
            if (lat !== elat[i]) $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, elat[i]);
            else passes++;
            checks++;
            if (res !== exp[i]) $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, exp[i]);
            else passes++;
            checks++;
            if (rdo !== 5'd5 || wr !== 1'b1 || bok !== 1'b1)
                $display("[TB] FAIL directed_wb[%0d]: got rd=%0d wr=%b busy_ok=%b expected rd=5 wr=1 busy_ok=1", i, rdo, wr, bok);
            else passes++;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("[TB] FAIL directed_pulse[%0d]: got done=%b busy=%b expected 0 0", i, done, busy);
            else passes++;
            last_result = exp[i]; last_rd = 5'd5;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, exp, res;
        logic [4:0]  rd, rdo;
        logic        wr, bok;
        int          lat, mode, sel;
        for (int i = 0; i < 24; i++) begin
            sel  = $urandom_range(0, 3);
            f3   = 3'b100 | 3'(sel);
            mode = $urandom_range(0, 5);
            a    = $urandom;
            b    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            if (mode == 1) b = 32'd0;
            if (mode == 2) b = 32'($urandom_range(1, 17));
            if (mode == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (mode == 4) b = -32'($urandom_range(1, 9));
            exp = model(f3, a, b);
            issue_and_wait(f3, a, b, rd, res, rdo, wr, lat, bok);
            checks++;
            if (res !== exp || lat !== model_latency(f3, a, b))
                $display("[TB] FAIL random[%0d] f3=%b a=%h b=%h: got %h lat %0d expected %h lat %0d",
                         i, f3, a, b, res, lat, exp, model_latency(f3, a, b));
            else passes++;
            checks++;
            if (rdo !== rd || wr !== (rd != 5'd0))
                $display("[TB] FAIL random_wb[%0d]: got rd=%0d wr=%b expected rd=%0d wr=%b", i, rdo, wr, rd, rd != 5'd0);
            else passes++;
            last_result = exp; last_rd = rd;
        end
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        start = 1'b1; funct3 = 3'b011; rs1_data = 32'd100; rs2_data = 32'd3; rd_in = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL ignore_non_div: got busy=%b expected 0", busy);
        else passes++;
        start = 1'b1; funct3 = 3'b100; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL ignore_flush_start: got busy=%b expected 0", busy);
        else passes++;
    endtask

    task automatic test_start_during_calc();
        int          ndone;
        logic [31:0] captured, exp;
        ndone = 0; captured = '0;
        exp = model(3'b101, 32'd1000, 32'd7);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd9;
        @(posedge clk);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin ndone++; captured = result; end
            if (k < 30) begin
                start = 1'b1; funct3 = 3'b100; rs1_data = $urandom; rs2_data = $urandom;
            end else start = 1'b0;
        end
        checks++;
        if (ndone !== 1 || captured !== exp)
            $display("[TB] FAIL start_in_calc: got %0d dones result %h expected 1 done result %h", ndone, captured, exp);
        else passes++;
        last_result = exp; last_rd = 5'd9;
    endtask

    task automatic test_flush();
        int          points[2] = '{9, 32};
        logic [31:0] res, exp;
        logic [4:0]  rdo;
        logic        wr, bok, seen;
        int          lat;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            start = 1'b1; funct3 = 3'b100; rs1_data = 32'd5000; rs2_data = 32'hFFFF_FFFD; rd_in = 5'd12;
            @(posedge clk);
            #1 start = 1'b0;
            for (int k = 0; k <= points[p]; k++) @(negedge clk);
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== last_result || rd_out !== last_rd)
                $display("[TB] FAIL flush_at_%0d: got busy=%b done=%b result=%h rd=%0d expected 0 0 %h %0d",
                         points[p], busy, done, result, rd_out, last_result, last_rd);
            else passes++;
            exp = model(3'b110, 32'hFFFF_FC00, 32'd37);
            issue_and_wait(3'b110, 32'hFFFF_FC00, 32'd37, 5'd3, res, rdo, wr, lat, bok);
            checks++;
            if (res !== exp || lat !== 33 || rdo !== 5'd3)
                $display("[TB] FAIL after_flush_%0d: got %h lat %0d rd %0d expected %h lat 33 rd 3", points[p], res, lat, rdo, exp);
            else passes++;
            last_result = exp; last_rd = 5'd3;
        end
        seen = 1'b0;
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL flush_spurious: got %b expected 0", seen);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1_data = 32'd77777; rs2_data = 32'd13; rd_in = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, write_reg, result, rd_out} !== 40'd0)
            $display("[TB] FAIL reset_mid: got busy=%b done=%b wr=%b result=%h rd=%0d expected all zero",
                     busy, done, write_reg, result, rd_out);
        else passes++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL reset_mid_done: got done seen=%b expected 0", seen);
        else passes++;
        last_result = '0; last_rd = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, exp_a, exp_b;
        logic [4:0]  rdo;
        logic        wr, bok;
        int          lat, n;
        exp_a = model(3'b111, 32'hDEAD_BEEF, 32'd1000);
        exp_b = model(3'b100, 32'hFFFF_0000, 32'd3);
        issue_and_wait(3'b111, 32'hDEAD_BEEF, 32'd1000, 5'd0, res, rdo, wr, lat, bok);
        checks++;
        if (res !== exp_a || wr !== 1'b0 || lat !== 33)
            $display("[TB] FAIL rd_zero: got %h wr=%b lat %0d expected %h wr=0 lat 33", res, wr, lat, exp_a);
        else passes++;
        start = 1'b1; funct3 = 3'b100; rs1_data = 32'hFFFF_0000; rs2_data = 32'd3; rd_in = 5'd31;
        n = -1;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (busy) start = 1'b0;
            if (done) begin n = k; res = result; wr = write_reg; break; end
        end
        start = 1'b0;
        checks++;
        if (n !== 35 || res !== exp_b || wr !== 1'b1)
            $display("[TB] FAIL start_in_done: got gap %0d result %h wr=%b expected gap 35 result %h wr=1", n, res, wr, exp_b);
        else passes++;
        last_result = exp_b; last_rd = 5'd31;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_start_during_calc();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
